// File: rtl/fp16_pkg.sv
// Shared fp16 constants and the state encoding of the MAC operand sequencer.
package fp16_pkg;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fp16_mac_sequencer.sv
// Feeds a vector of fp16 operand pairs into the MAC, waits out its pipeline latency
// and presents the accumulated dot product on a valid/ready result port.
module fp16_mac_sequencer
  import fp16_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3,
  parameter int CLR_CYC = 2
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_clr_n,
  input  logic [15:0]      mac_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy
);

  localparam int SUB_MAX = (MAC_LAT > CLR_CYC) ? MAC_LAT : CLR_CYC;
  localparam int SUB_W   = (SUB_MAX > 1) ? $clog2(SUB_MAX) : 1;

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [15:0]      a_q, a_d, b_q, b_d;
  logic             clr_n_q, clr_n_d;
  logic             ov_q, ov_d;
  logic [15:0]      od_q, od_d;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= '0;
      a_q     <= FP16_ZERO;
      b_q     <= FP16_ZERO;
      clr_n_q <= 1'b1;
      ov_q    <= 1'b0;
      od_q    <= FP16_ZERO;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      clr_n_q <= clr_n_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  // Operands default to zero every cycle, so any non-beat cycle issues a 0*0 bubble.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    a_d     = FP16_ZERO;
    b_d     = FP16_ZERO;
    clr_n_d = 1'b1;
    ov_d    = ov_q;
    od_d    = od_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (vec_len != '0) begin
            len_d   = vec_len;
            cnt_d   = '0;
            sub_d   = '0;
            clr_n_d = 1'b0;
            state_d = ST_CLEAR;
          end else begin
            od_d    = FP16_ZERO;
            ov_d    = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_CLEAR: begin
        if (sub_q == SUB_W'(CLR_CYC - 1)) begin
          sub_d   = '0;
          state_d = ST_FEED;
        end else begin
          sub_d   = sub_q + 1'b1;
          clr_n_d = 1'b0;
        end
      end
      ST_FEED: begin
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          if (cnt_q == len_q - LEN_W'(1)) begin
            sub_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (sub_q == SUB_W'(MAC_LAT - 1)) begin
          sub_d   = '0;
          od_d    = mac_acc;
          ov_d    = 1'b1;
          state_d = ST_HOLD;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_FEED);
  assign busy      = (state_q != ST_IDLE);
  assign mac_a     = a_q;
  assign mac_b     = b_q;
  assign mac_clr_n = clr_n_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;

endmodule

// File: tb/tb_fp16_mac_sequencer.sv
// Directed bench for fp16_mac_sequencer driving a behavioural two-stage fp16 MAC.
module tb_fp16_mac_sequencer;
  import fp16_pkg::*;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        start;
  logic [7:0]  vec_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic [15:0] mac_a, mac_b;
  logic        mac_clr_n;
  logic [15:0] mac_acc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic        mac_rst_n;

  int checks = 0;
  int errors = 0;
  logic [15:0] va [0:7];
  logic [15:0] vb [0:7];

  always #5 CLK = ~CLK;

  fp16_mac_sequencer #(.LEN_W(8), .MAC_LAT(3), .CLR_CYC(2)) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr_n(mac_clr_n), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    int e = int'(h[14:10]);
    int m = int'(h[9:0]);
    real v;
    if (e == 0) v = $itor(m) * pow2(-24);
    else        v = $itor(1024 + m) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real r);
    logic s;
    int   e, m, guard;
    real  x;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    x = s ? -r : r;
    e = 15;
    guard = 0;
    while (x >= 2.0 && guard < 40) begin x = x / 2.0; e++; guard++; end
    while (x < 1.0 && guard < 80) begin x = x * 2.0; e--; guard++; end
    m = $rtoi((x - 1.0) * 1024.0);
    return {s, 5'(e), 10'(m)};
  endfunction

  // Behavioural MAC: product register, then accumulator; reset also driven by mac_clr_n.
  real prod_r, acc_r;
  assign mac_rst_n = RESETn & mac_clr_n;
  always @(posedge CLK or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      prod_r <= 0.0;
      acc_r  <= 0.0;
    end else begin
      prod_r <= fp16_to_real(mac_a) * fp16_to_real(mac_b);
      acc_r  <= acc_r + prod_r;
    end
  end
  always_comb mac_acc = real_to_fp16(acc_r);

  task automatic test_reset();
    RESETn = 1'b0; start = 1'b0; vec_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if ({mac_a, mac_b} !== 32'h0) begin errors++; $display("FAIL reset_mac_ab: got %h expected 00000000", {mac_a, mac_b}); end
    checks++; if (mac_clr_n !== 1'b1) begin errors++; $display("FAIL reset_clr_n: got %b expected 1", mac_clr_n); end
    checks++; if ({out_valid, out_data} !== 17'h0) begin errors++; $display("FAIL reset_out: got %b/%h expected 0/0000", out_valid, out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    RESETn = 1'b1;
  endtask

  // Runs one vector from va/vb. gap = idle in_valid cycles after each beat,
  // hold_cyc = cycles out_ready is held low once the result is valid (0: ready always high),
  // exp_lat = expected start->out_valid cycles (0 skips the check).
  task automatic run_vector(input string name, input int len, input int gap,
                            input int hold_cyc, input logic [15:0] exp, input int exp_lat);
    int idx = 0, gapcnt = 0, clr_cnt = 0, lat = 0;
    bit prev_v = 0, prev_r = 0, seen_ready = 0, done = 0;
    logic [15:0] exp_a, exp_b;
    start = 1'b1; vec_len = 8'(len); in_valid = 1'b0;
    out_ready = (hold_cyc == 0);
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge CLK);
      start = 1'b0;
      if (prev_v && prev_r) begin
        exp_a = va[idx]; exp_b = vb[idx]; idx++; gapcnt = gap;
      end else begin
        exp_a = FP16_ZERO; exp_b = FP16_ZERO;
      end
      checks++;
      if ({mac_a, mac_b} !== {exp_a, exp_b}) begin
        errors++; $display("FAIL %s_mac_ab cyc%0d: got %h/%h expected %h/%h", name, cyc, mac_a, mac_b, exp_a, exp_b);
      end
      if (!mac_clr_n) clr_cnt++;
      if (in_ready) seen_ready = 1;
      if (seen_ready) begin
        checks++;
        if (in_ready !== (idx < len)) begin
          errors++; $display("FAIL %s_in_ready cyc%0d: got %b expected %b", name, cyc, in_ready, idx < len);
        end
      end
      if (idx < len && gapcnt == 0) begin
        in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx];
      end else begin
        in_valid = 1'b0; in_a = '0; in_b = '0;
        if (gapcnt > 0) gapcnt--;
      end
      prev_v = in_valid; prev_r = in_ready;
      if (out_valid === 1'b1) begin
        done = 1; lat = cyc;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++; $display("FAIL %s_timeout: got no out_valid expected out_valid within 300 cycles", name);
      return;
    end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", name, out_data, exp); end
    if (exp_lat > 0) begin
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    end
    checks++;
    if (clr_cnt != ((len != 0) ? 2 : 0)) begin
      errors++; $display("FAIL %s_clr_cycles: got %0d expected %0d", name, clr_cnt, (len != 0) ? 2 : 0);
    end
    if (hold_cyc == 0) begin
      @(negedge CLK);
      checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL %s_one_cycle: got valid/busy %b%b expected 00", name, out_valid, busy); end
    end else begin
      for (int k = 1; k < hold_cyc; k++) begin
        @(negedge CLK);
        start = (k == 1); vec_len = 8'd5;
        checks++;
        if ({out_valid, out_data, busy} !== {1'b1, exp, 1'b1}) begin
          errors++; $display("FAIL %s_hold k%0d: got v%b d%h b%b expected v1 d%h b1", name, k, out_valid, out_data, busy, exp);
        end
      end
      @(negedge CLK);
      start = 1'b0; out_ready = 1'b1;
      checks++; if ({out_valid, out_data} !== {1'b1, exp}) begin errors++; $display("FAIL %s_handshake: got %b/%h expected 1/%h", name, out_valid, out_data, exp); end
      @(negedge CLK);
      out_ready = 1'b0;
      checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL %s_release: got valid/busy %b%b expected 00", name, out_valid, busy); end
      @(negedge CLK);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_start_ignored: got busy %b expected 0", name, busy); end
    end
  endtask

  task automatic test_back_to_back_beats();
    va[0] = 16'h3C00; vb[0] = 16'h4200; va[1] = 16'h4000; vb[1] = 16'h4400;
    run_vector("b2b_beats", 2, 0, 0, 16'h4980, 8);
  endtask

  task automatic test_gaps();
    va[0] = 16'h3C00; vb[0] = 16'h4200; va[1] = 16'h4000; vb[1] = 16'h4400;
    run_vector("gaps", 2, 3, 0, 16'h4980, 0);
  endtask

  task automatic test_zero_len();
    run_vector("zero_len", 0, 0, 0, FP16_ZERO, 1);
  endtask

  task automatic test_hold();
    va[0] = FP16_ONE; vb[0] = FP16_ONE;
    run_vector("hold", 1, 0, 6, FP16_ONE, 7);
  endtask

  task automatic test_reset_mid_feed();
    bit got_ready = 0;
    va[0] = 16'h4400; vb[0] = 16'h4400;
    @(negedge CLK);
    start = 1'b1; vec_len = 8'd3;
    @(negedge CLK);
    start = 1'b0; in_valid = 1'b1; in_a = va[0]; in_b = vb[0];
    for (int i = 0; i < 20 && !got_ready; i++) begin
      @(negedge CLK);
      if (in_ready) got_ready = 1;
    end
    checks++; if (!got_ready) begin errors++; $display("FAIL abort_feed_timeout: got in_ready 0 expected 1"); end
    @(negedge CLK);
    checks++; if (mac_a !== 16'h4400) begin errors++; $display("FAIL abort_first_beat: got %h expected 4400", mac_a); end
    in_valid = 1'b0; in_a = '0; in_b = '0;
    RESETn = 1'b0;
    #1;
    checks++;
    if ({in_ready, mac_a, mac_b, mac_clr_n, out_valid, out_data, busy} !== {1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0}) begin
      errors++; $display("FAIL abort_reset_outputs: got rdy%b a%h b%h clr%b v%b d%h busy%b expected rdy0 a0000 b0000 clr1 v0 d0000 busy0",
                         in_ready, mac_a, mac_b, mac_clr_n, out_valid, out_data, busy);
    end
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    va[0] = 16'h4000; vb[0] = 16'h4000;
    run_vector("after_abort", 1, 0, 0, 16'h4400, 7);
  endtask

  task automatic test_back_to_back_vectors();
    va[0] = 16'h4200; vb[0] = 16'h4000;
    run_vector("vec_a", 1, 0, 0, 16'h4600, 7);
    va[0] = 16'h3C00; vb[0] = 16'h4400;
    run_vector("vec_b", 1, 0, 0, 16'h4400, 7);
  endtask

  initial begin
    test_reset();
    test_back_to_back_beats();
    test_gaps();
    test_zero_len();
    test_hold();
    test_reset_mid_feed();
    test_back_to_back_vectors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
